// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage pipeline. It sits downstream of the
// EX/MEM register and does four jobs:
//   - runs a request/acknowledge handshake with data memory for loads and stores
//   - aborts an access that waits too long and sets a sticky error flag
//   - resolves branches
//   - holds the MEM/WB pipeline register
// hit is the advance enable for everything upstream. It is low while an
// access is outstanding.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_ctlwb,
    input  logic [2:0]  i_ctlmem,
    input  logic        ialu_zero,
    input  logic [31:0] iadder_output,
    input  logic [31:0] ialu_output,
    input  logic [31:0] iread_dat_2,
    input  logic [4:0]  imux_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        hit,
    output logic        pc_src,
    output logic [31:0] obranch_target,
    output logic        mem_err,
    output logic [1:0]  o_ctlwb,
    output logic [31:0] oread_data,
    output logic [31:0] oalu_output,
    output logic [4:0]  omux_out
);

    // state   | meaning
    // IDLE    | no access outstanding; a new access is latched and issued from here
    // WAIT    | request held on the memory bus until it is acknowledged or times out
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Last value of the wait counter before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        is_read_q;

    logic        access;
    logic        start_access;
    logic        abort;
    logic [31:0] load_data;

    // A single MEM control bit is enough to require a memory access.
    assign access = i_ctlmem[1] | i_ctlmem[0];

    // Next state, upstream advance enable, and abort detection.
    always_comb begin
        state_next   = state;
        hit          = 1'b1;
        abort        = 1'b0;
        start_access = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    hit          = 1'b0;
                    start_access = 1'b1;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    hit = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register. Reset returns to IDLE, which drops any live request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait-cycle counter. It is cleared when an access is issued. The abort
    // fires before the counter can wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (start_access) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_WAIT && !mem_ack && !abort) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Request latches. They are loaded once per access, so the bus stays stable
    // for the whole of WAIT and keeps its last value afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            is_read_q <= 1'b0;
        end else if (start_access) begin
            addr_q    <= {ialu_output[31:2], 2'b00};
            wdata_q   <= iread_dat_2;
            // When MemRead and MemWrite are both set, the access is a read.
            we_q      <= i_ctlmem[0] & ~i_ctlmem[1];
            is_read_q <= i_ctlmem[1];
        end
    end

    assign mem_req   = (state == ST_WAIT);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Load data reaches MEM/WB only on a completed read.
    // Stores and non-access instructions write zero.
    assign load_data = (state == ST_WAIT && is_read_q) ? mem_rdata : 32'd0;

    assign pc_src         = i_ctlmem[2] & ialu_zero & hit;
    assign obranch_target = iadder_output;

    // MEM/WB register. A stall or an abort inserts a bubble by clearing only
    // the WB controls; the data fields hold their values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ctlwb     <= 2'b00;
            oread_data  <= 32'd0;
            oalu_output <= 32'd0;
            omux_out    <= 5'd0;
        end else if (hit && !abort) begin
            o_ctlwb     <= i_ctlwb;
            oread_data  <= load_data;
            oalu_output <= ialu_output;
            omux_out    <= imux_out;
        end else begin
            o_ctlwb <= 2'b00;
        end
    end

    // Sticky timeout flag. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (abort) begin
            mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. It runs with TIMEOUT=4 so a timeout sequence stays short.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  i_ctlwb;
    logic [2:0]  i_ctlmem;
    logic        ialu_zero;
    logic [31:0] iadder_output;
    logic [31:0] ialu_output;
    logic [31:0] iread_dat_2;
    logic [4:0]  imux_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        pc_src;
    logic [31:0] obranch_target;
    logic        mem_err;
    logic [1:0]  o_ctlwb;
    logic [31:0] oread_data;
    logic [31:0] oalu_output;
    logic [4:0]  omux_out;

    int checks;
    int failures;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_ctlwb(i_ctlwb), .i_ctlmem(i_ctlmem), .ialu_zero(ialu_zero),
        .iadder_output(iadder_output), .ialu_output(ialu_output),
        .iread_dat_2(iread_dat_2), .imux_out(imux_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit(hit), .pc_src(pc_src), .obranch_target(obranch_target),
        .mem_err(mem_err), .o_ctlwb(o_ctlwb), .oread_data(oread_data),
        .oalu_output(oalu_output), .omux_out(omux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctlwb;
        logic [2:0]  ctlmem;
        logic        zero;
        logic [31:0] adder;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  mux;
        logic        exp_pc_src;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic z,
                         input logic [31:0] adder, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] mux);
        i_ctlwb       = wb;
        i_ctlmem      = m;
        ialu_zero     = z;
        iadder_output = adder;
        ialu_output   = alu;
        iread_dat_2   = rd2;
        imux_out      = mux;
    endtask

    vec_t vecs[4];

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        drive(2'b00, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);

        // Reset with ack stuck high.
        tick();
        tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd1);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("rst_o_ctlwb", {30'd0, o_ctlwb}, 32'd0);
        check("rst_oread", oread_data, 32'd0);
        check("rst_oalu", oalu_output, 32'd0);
        check("rst_omux", {27'd0, omux_out}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ack_ignored_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;

        // Single-cycle instructions that need no memory access.
        vecs[0] = '{2'b10, 3'b000, 1'b0, 32'h0000_0000, 32'h0000_1234, 32'h0, 5'd5,  1'b0};
        vecs[1] = '{2'b00, 3'b100, 1'b1, 32'h0000_0080, 32'h0000_0000, 32'h0, 5'd0,  1'b1};
        vecs[2] = '{2'b00, 3'b100, 1'b0, 32'h0000_0080, 32'h0000_0007, 32'h0, 5'd0,  1'b0};
        vecs[3] = '{2'b11, 3'b000, 1'b1, 32'h1111_2222, 32'hFFFF_FFFF, 32'h9, 5'd31, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].ctlwb, vecs[i].ctlmem, vecs[i].zero, vecs[i].adder,
                  vecs[i].alu, vecs[i].rd2, vecs[i].mux);
            #1;
            check($sformatf("v%0d_hit", i), {31'd0, hit}, 32'd1);
            check($sformatf("v%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_pc_src});
            check($sformatf("v%0d_target", i), obranch_target, vecs[i].adder);
            check($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, 32'd0);
            tick();
            check($sformatf("v%0d_o_ctlwb", i), {30'd0, o_ctlwb}, {30'd0, vecs[i].ctlwb});
            check($sformatf("v%0d_oalu", i), oalu_output, vecs[i].alu);
            check($sformatf("v%0d_omux", i), {27'd0, omux_out}, {27'd0, vecs[i].mux});
            check($sformatf("v%0d_oread", i), oread_data, 32'd0);
        end

        // Load from 0x103; the ack arrives in the third WAIT cycle.
        drive(2'b11, 3'b010, 1'b0, 32'h0, 32'h0000_0103, 32'h0, 5'd7);
        #1;
        check("ld_idle_hit", {31'd0, hit}, 32'd0);
        check("ld_idle_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("ld_w1_req", {31'd0, mem_req}, 32'd1);
        check("ld_w1_addr", mem_addr, 32'h0000_0100);
        check("ld_w1_we", {31'd0, mem_we}, 32'd0);
        check("ld_w1_hit", {31'd0, hit}, 32'd0);
        check("ld_w1_bubble", {30'd0, o_ctlwb}, 32'd0);
        tick();
        check("ld_w2_hit", {31'd0, hit}, 32'd0);
        check("ld_w2_bubble", {30'd0, o_ctlwb}, 32'd0);
        check("ld_w2_addr", mem_addr, 32'h0000_0100);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_w3_hit", {31'd0, hit}, 32'd1);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        #1;
        check("ld_o_ctlwb", {30'd0, o_ctlwb}, 32'd3);
        check("ld_oread", oread_data, 32'hDEAD_BEEF);
        check("ld_oalu", oalu_output, 32'h0000_0103);
        check("ld_omux", {27'd0, omux_out}, 32'd7);
        check("ld_done_req", {31'd0, mem_req}, 32'd0);
        check("ld_done_hit", {31'd0, hit}, 32'd1);
        tick();

        // Store 0xCAFEF00D to 0x40, acknowledged in the same cycle the request rises.
        drive(2'b00, 3'b001, 1'b0, 32'h0, 32'h0000_0040, 32'hCAFE_F00D, 5'd3);
        #1;
        check("st_idle_hit", {31'd0, hit}, 32'd0);
        tick();
        mem_ack = 1'b1;
        #1;
        check("st_we", {31'd0, mem_we}, 32'd1);
        check("st_wdata", mem_wdata, 32'hCAFE_F00D);
        check("st_addr", mem_addr, 32'h0000_0040);
        check("st_hit", {31'd0, hit}, 32'd1);
        tick();
        mem_ack = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        #1;
        check("st_done_req", {31'd0, mem_req}, 32'd0);
        check("st_done_we", {31'd0, mem_we}, 32'd0);
        check("st_hold_wdata", mem_wdata, 32'hCAFE_F00D);
        check("st_oread", oread_data, 32'd0);
        check("st_oalu", oalu_output, 32'h0000_0040);
        tick();

        // MemRead and MemWrite both set: treated as a read, so no write enable.
        drive(2'b01, 3'b011, 1'b0, 32'h0, 32'h0000_0088, 32'h1234_5678, 5'd9);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        check("rw_we", {31'd0, mem_we}, 32'd0);
        check("rw_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        #1;
        check("rw_oread", oread_data, 32'h0BAD_F00D);
        tick();

        // Timeout with no ack. TIMEOUT=4, so the abort happens at the end of the fourth WAIT cycle.
        drive(2'b10, 3'b010, 1'b0, 32'h0, 32'h0000_0200, 32'h0, 5'd4);
        tick();
        for (int w = 1; w <= 3; w++) begin
            check($sformatf("to_w%0d_hit", w), {31'd0, hit}, 32'd0);
            check($sformatf("to_w%0d_req", w), {31'd0, mem_req}, 32'd1);
            tick();
        end
        check("to_w4_hit", {31'd0, hit}, 32'd1);
        check("to_w4_err_before", {31'd0, mem_err}, 32'd0);
        tick();
        drive(2'b10, 3'b000, 1'b0, 32'h0, 32'h0000_0055, 32'h0, 5'd6);
        #1;
        check("to_err", {31'd0, mem_err}, 32'd1);
        check("to_bubble", {30'd0, o_ctlwb}, 32'd0);
        check("to_req", {31'd0, mem_req}, 32'd0);
        check("to_next_hit", {31'd0, hit}, 32'd1);
        tick();
        check("to_next_ctlwb", {30'd0, o_ctlwb}, 32'd2);
        check("to_next_oalu", oalu_output, 32'h0000_0055);
        check("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // Reset while in WAIT. The request must drop immediately and a late ack must be ignored.
        drive(2'b11, 3'b010, 1'b0, 32'h0, 32'h0000_0300, 32'h0, 5'd8);
        tick();
        check("rw_mid_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req_drop", {31'd0, mem_req}, 32'd0);
        check("rst_mid_err_clr", {31'd0, mem_err}, 32'd0);
        drive(2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_late_ack_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_late_ack_hit", {31'd0, hit}, 32'd1);
        check("rst_mid_oread", oread_data, 32'd0);
        mem_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
